multdiv_unit: RTL and testbench
===============================

// Module: multdiv_unit
// PURPOSE
//  Multi-cycle responder for decoded MULT/MULTU/DIV/DIVU/MADD(U)/MSUB(U)/MUL ops issued by decode/execute.
//  Owns architectural HI/LO registers and services MTHI/MTLO writes.
//  Sits beside the ALU in execute. It holds the pipeline via ready_o/busy_o until done_o.
// PARAMETERS
//  MULT_LATENCY  3   cycles spent in MUL_BUSY (product register stages, >=1)
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  reset      in   1   synchronous, active-high reset
//  valid_i    in   1   request valid; accepted when valid_i & ready_o & !flush_i
//  op_i       in   md_op_t  operation (MD_MULT,MULTU,DIV,DIVU,MADD,MADDU,MSUB,MSUBU,MUL)
//  a_i        in   32  rs operand (dividend / multiplicand)
//  b_i        in   32  rt operand (divisor / multiplier)
//  flush_i    in   1   abort in-flight op (exception/ERET); HI/LO untouched
//  hi_we_i    in   1   MTHI write enable
//  lo_we_i    in   1   MTLO write enable
//  wdata_i    in   32  MTHI/MTLO data
//  ready_o    out  1   1 only in IDLE
//  busy_o     out  1   !ready_o
//  done_o     out  1   one-cycle pulse: op committed, hi_o/lo_o/result_o valid
//  result_o   out  32  MUL GPR result (product[31:0]); 0 for other ops
//  hi_o       out  32  architectural HI
//  lo_o       out  32  architectural LO
// BEHAVIOUR
//  Reset: state=IDLE; hi_o=lo_o=result_o=0; done_o=0; ready_o=1; counters=0.
//  FSM: IDLE, MUL_BUSY, DIV_BUSY, DIV_FIX.
//   - IDLE --accept mult-class op--> MUL_BUSY. Operands latched; cnt=MULT_LATENCY-1.
//   - MUL_BUSY: cnt decrements. At cnt==0: commit, -> IDLE.
//   - IDLE --accept DIV/DIVU--> DIV_BUSY. Latch |a|,|b| (DIV) or raw (DIVU); cnt=31.
//   - DIV_BUSY: one restoring step per cycle, MSB first. At cnt==0 -> DIV_FIX.
//   - DIV_FIX: sign fixup, commit, -> IDLE.
//  Commit edge updates HI/LO/result_o. done_o is registered: high exactly the cycle after the commit edge.
//  Latency from the accept edge to the done_o cycle: mult-class = MULT_LATENCY+1; DIV/DIVU = 34.
//  Arithmetic:
//   - MULT/MADD/MSUB: 64b signed product. *U variants: unsigned.
//   - MADD*: {hi,lo} += prod; MSUB*: {hi,lo} -= prod, mod 2^64.
//     Accumulate uses the HI/LO value at the commit edge.
//   - MUL: result_o = prod[31:0]; HI/LO unchanged.
//   - DIV: q sign = a[31]^b[31]; r sign = a[31]; negate via two's complement. 0x80000000/-1 -> lo=0x80000000, hi=0.
//   - Divide by zero: core yields q=0xFFFFFFFF, r=|a| (DIV) or a (DIVU); sign fixup still applied. Deterministic.
//  flush_i:
//   - In MUL_BUSY/DIV_BUSY/DIV_FIX: -> IDLE next edge, no commit, no done_o.
//   - With valid_i in IDLE: request not accepted.
//   - During the done_o cycle: no effect, already committed.
//  MTHI/MTLO: hi_we_i/lo_we_i write on the next edge in any state.
//   - If coincident with a commit edge, the commit wins for the registers it writes; MUL commit does not block them.
//  valid_i while busy: ignored (ready_o=0), no queueing.
//  Reset mid-operation: immediate return to reset values; no done_o.
// STRUCTURE
//  md_op_t enum and MD_DIV_STEPS=32 go in the shared decode package; execute maps decoded_op_t onto md_op_t.
//  Sub-module divider_radix2: 32-step unsigned restoring core.
//   - Ports: clk, reset, start, abort, dividend, divisor -> quotient, remainder, last.
//  The sign fixup and the multiply path stay in multdiv_unit.
// TESTING
//  1 Reset, then idle 5 cycles -> hi_o=lo_o=0, ready_o=1, done_o never high.
//  2 MULT a=0xFFFFFFFE(-2) b=3 -> done_o 4 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
//    Same operands with MULTU -> hi=0x2, lo=0xFFFFFFFA.
//  3 DIV a=-7 b=2 -> done_o 34 cycles after accept; lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
//    DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
//  4 MTHI 0, MTLO 10, then MADDU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x0000000B.
//    Then MSUB a=1 b=1 -> lo=0x0000000A.
//  5 DIV accepted, flush_i at cycle 10 -> ready_o=1 next cycle, no done_o, HI/LO unchanged.
//    New MULT accepted the following cycle completes normally.
//  6 MUL a=5 b=6 with HI/LO=0x11/0x22 -> result_o=30 on the done_o cycle, HI/LO unchanged.
//    lo_we_i on the MUL commit edge -> LO takes wdata_i.

Source files
------------

// File: rtl/multdiv_unit_pkg.sv
// Shared decode-side types for the multiply/divide unit: operation encoding,
// FSM states, step counts and the HI/LO/result payload.
package multdiv_unit_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned MD_DIV_STEPS = 32;
    localparam int unsigned MD_CNT_W     = 5;

    typedef enum logic [3:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU,
        MD_MADD,
        MD_MADDU,
        MD_MSUB,
        MD_MSUBU,
        MD_MUL
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL_BUSY,
        ST_DIV_BUSY,
        ST_DIV_FIX
    } md_state_t;

    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
        logic [XLEN-1:0] result;
    } md_res_t;

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // MUL is the signed three-operand form, so it shares the signed product.
    function automatic logic md_is_signed_mult(input md_op_t op);
        return (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB) || (op == MD_MUL);
    endfunction

endpackage

// File: rtl/multdiv_unit_divider_radix2.sv
// 32-step unsigned restoring divider, one quotient bit per cycle, MSB first.
// A zero divisor yields quotient all-ones and remainder equal to the dividend.
module divider_radix2
    import multdiv_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            abort_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o,
    output logic            last_o
);

    logic [XLEN-1:0]     quo_q, quo_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [XLEN-1:0]     dvs_q, dvs_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                last_q, last_d;
    logic [XLEN:0]       trial_c;
    logic [XLEN:0]       diff_c;

    // Trial subtract of the shifted partial remainder; borrow selects restore.
    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        last_d  = 1'b0;
        trial_c = {rem_q, quo_q[XLEN-1]};
        diff_c  = trial_c - {1'b0, dvs_q};

        if (abort_i) begin
            busy_d = 1'b0;
        end else if (start_i) begin
            quo_d  = dividend_i;
            rem_d  = '0;
            dvs_d  = divisor_i;
            cnt_d  = MD_CNT_W'(MD_DIV_STEPS - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (!diff_c[XLEN]) begin
                rem_d = diff_c[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = trial_c[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
            cnt_d = cnt_q - MD_CNT_W'(1);
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                last_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            last_q <= last_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign last_o      = last_q;

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle MIPS multiply/divide unit owning architectural HI/LO.
// Holds the pipeline via ready_o/busy_o and pulses done_o after each commit.
module multdiv_unit
    import multdiv_unit_pkg::*;
#(
    parameter int unsigned MULT_LATENCY = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_i,
    input  md_op_t          op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    input  logic            hi_we_i,
    input  logic            lo_we_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            ready_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    localparam int unsigned PW = 2 * XLEN;

    md_state_t           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    md_op_t              op_q, op_d;
    logic [PW-1:0]       prod_q, prod_d;
    logic                q_neg_q, q_neg_d;
    logic                r_neg_q, r_neg_d;
    logic [XLEN-1:0]     hi_q, hi_d;
    logic [XLEN-1:0]     lo_q, lo_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;

    logic                accept_c;
    logic                div_signed_c;
    logic [PW-1:0]       a_ext_c, b_ext_c, mult_c;
    logic [XLEN-1:0]     a_div_c, b_div_c;
    logic                div_start_c, div_abort_c;
    logic [XLEN-1:0]     div_quo, div_rem;
    logic                div_last;
    logic [XLEN-1:0]     q_fix_c, r_fix_c;
    logic [PW-1:0]       hilo_c;

    always_comb begin
        accept_c     = valid_i && ready_q && !flush_i;
        div_signed_c = (op_i == MD_DIV);
        a_ext_c      = md_is_signed_mult(op_i) ? {{XLEN{a_i[XLEN-1]}}, a_i} : {{XLEN{1'b0}}, a_i};
        b_ext_c      = md_is_signed_mult(op_i) ? {{XLEN{b_i[XLEN-1]}}, b_i} : {{XLEN{1'b0}}, b_i};
        mult_c       = a_ext_c * b_ext_c;
        a_div_c      = (div_signed_c && a_i[XLEN-1]) ? -a_i : a_i;
        b_div_c      = (div_signed_c && b_i[XLEN-1]) ? -b_i : b_i;
        div_start_c  = accept_c && md_is_div(op_i);
        div_abort_c  = flush_i && ((state_q == ST_DIV_BUSY) || (state_q == ST_DIV_FIX));
        q_fix_c      = q_neg_q ? -div_quo : div_quo;
        r_fix_c      = r_neg_q ? -div_rem : div_rem;
        hilo_c       = {hi_q, lo_q};
    end

    divider_radix2 u_div (
        .clk         (clk),
        .reset       (reset),
        .start_i     (div_start_c),
        .abort_i     (div_abort_c),
        .dividend_i  (a_div_c),
        .divisor_i   (b_div_c),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .last_o      (div_last)
    );

    // Next state; MTHI/MTLO land by default and a commit overrides what it writes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        prod_d   = prod_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        hi_d     = hi_we_i ? wdata_i : hi_q;
        lo_d     = lo_we_i ? wdata_i : lo_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    op_d = op_i;
                    if (md_is_div(op_i)) begin
                        state_d = ST_DIV_BUSY;
                        cnt_d   = MD_CNT_W'(MD_DIV_STEPS - 1);
                        q_neg_d = div_signed_c && (a_i[XLEN-1] ^ b_i[XLEN-1]);
                        r_neg_d = div_signed_c && a_i[XLEN-1];
                    end else begin
                        state_d = ST_MUL_BUSY;
                        cnt_d   = MD_CNT_W'(MULT_LATENCY - 1);
                        prod_d  = mult_c;
                    end
                end
            end
            ST_MUL_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    result_d = '0;
                    unique case (op_q)
                        MD_MADD, MD_MADDU: {hi_d, lo_d} = hilo_c + prod_q;
                        MD_MSUB, MD_MSUBU: {hi_d, lo_d} = hilo_c - prod_q;
                        MD_MUL:            result_d = prod_q[XLEN-1:0];
                        default:           {hi_d, lo_d} = prod_q;
                    endcase
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            ST_DIV_BUSY: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_DIV_FIX;
                end else begin
                    cnt_d = cnt_q - MD_CNT_W'(1);
                end
            end
            ST_DIV_FIX: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else if (div_last) begin
                    state_d  = ST_IDLE;
                    done_d   = 1'b1;
                    lo_d     = q_fix_c;
                    hi_d     = r_fix_c;
                    result_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= MD_MULT;
            prod_q   <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            prod_q   <= prod_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign ready_o  = ready_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Scoreboard bench for multdiv_unit: expected HI/LO/result queued at issue,
// popped and compared on each done_o pulse.
module tb_multdiv_unit;
    import multdiv_unit_pkg::*;

    localparam int MULT_LAT = 3;
    localparam int DIV_LAT  = 34;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    md_op_t      op_i;
    logic [31:0] a_i, b_i;
    logic        flush_i, hi_we_i, lo_we_i;
    logic [31:0] wdata_i;
    logic        ready_o, busy_o, done_o;
    logic [31:0] result_o, hi_o, lo_o;

    int          total = 0;
    int          bad   = 0;
    md_res_t     exp_q[$];
    logic [31:0] m_hi, m_lo;

    multdiv_unit #(.MULT_LATENCY(MULT_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .valid_i  (valid_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .flush_i  (flush_i),
        .hi_we_i  (hi_we_i),
        .lo_we_i  (lo_we_i),
        .wdata_i  (wdata_i),
        .ready_o  (ready_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic md_res_t model(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] hi, input logic [31:0] lo);
        md_res_t     r;
        longint      sa, sb;
        logic [63:0] ps, pu;
        logic [31:0] q, rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ps = 64'(sa * sb);
        pu = {32'b0, a} * {32'b0, b};
        r.hi = hi;
        r.lo = lo;
        r.result = 32'h0;
        q  = 32'h0;
        rr = 32'h0;
        case (op)
            MD_MULT:  {r.hi, r.lo} = ps;
            MD_MULTU: {r.hi, r.lo} = pu;
            MD_MADD:  {r.hi, r.lo} = {hi, lo} + ps;
            MD_MADDU: {r.hi, r.lo} = {hi, lo} + pu;
            MD_MSUB:  {r.hi, r.lo} = {hi, lo} - ps;
            MD_MSUBU: {r.hi, r.lo} = {hi, lo} - pu;
            MD_MUL:   r.result = ps[31:0];
            MD_DIV: begin
                if (b == 32'h0) begin
                    q  = 32'hFFFF_FFFF;
                    rr = a[31] ? -a : a;
                    if (a[31]) begin
                        q  = -q;
                        rr = -rr;
                    end
                end else begin
                    q  = 32'(sa / sb);
                    rr = 32'(sa % sb);
                end
                r.lo = q;
                r.hi = rr;
            end
            MD_DIVU: begin
                if (b == 32'h0) begin
                    r.lo = 32'hFFFF_FFFF;
                    r.hi = a;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    // Issue one op, optionally with MTHI/MTLO on the commit edge, and score it.
    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic mt_hi, input logic mt_lo, input logic [31:0] mt_data);
        int      exp_lat, n;
        logic    seen;
        md_res_t e, got;
        exp_lat = md_is_div(op) ? DIV_LAT : MULT_LAT + 1;
        e = model(op, a, b, m_hi, m_lo);
        if (op == MD_MUL) begin
            if (mt_hi) e.hi = mt_data;
            if (mt_lo) e.lo = mt_data;
        end
        exp_q.push_back(e);
        m_hi = e.hi;
        m_lo = e.lo;

        @(negedge clk);
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
        @(posedge clk);
        n = 1;
        #1 valid_i = 1'b0;
        seen = 1'b0;
        while (!seen && n < 60) begin
            @(negedge clk);
            if (done_o) begin
                seen = 1'b1;
            end else begin
                if (n == 1) chk("busy_after_accept", 64'({ready_o, busy_o}), 64'(2'b01));
                if (n == exp_lat - 1) begin
                    hi_we_i = mt_hi; lo_we_i = mt_lo; wdata_i = mt_data;
                end
                @(posedge clk);
                n++;
                #1 hi_we_i = 1'b0; lo_we_i = 1'b0;
            end
        end
        chk("done_seen", 64'(seen), 64'(1));
        got = exp_q.pop_front();
        if (seen) begin
            chk("latency", 64'(n), 64'(exp_lat));
            chk("hi", 64'(hi_o), 64'(got.hi));
            chk("lo", 64'(lo_o), 64'(got.lo));
            chk("result", 64'(result_o), 64'(got.result));
            chk("ready_on_done", 64'(ready_o), 64'(1));
            @(negedge clk);
            chk("done_pulse", 64'(done_o), 64'(0));
        end
    endtask

    task automatic mt(input logic wh, input logic wl, input logic [31:0] d);
        @(negedge clk);
        hi_we_i = wh; lo_we_i = wl; wdata_i = d;
        @(posedge clk);
        #1 hi_we_i = 1'b0; lo_we_i = 1'b0;
        if (wh) m_hi = d;
        if (wl) m_lo = d;
        @(negedge clk);
        chk("mt_hi", 64'(hi_o), 64'(m_hi));
        chk("mt_lo", 64'(lo_o), 64'(m_lo));
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done_o) hits++;
        end
        chk(tag, 64'(hits), 64'(0));
    endtask

    initial begin
        md_op_t rop;
        reset = 1'b1; valid_i = 1'b0; op_i = MD_MULT; a_i = '0; b_i = '0;
        flush_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0;
        m_hi = '0; m_lo = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // reset state and idle
        watch_no_done("idle_done", 5);
        chk("rst_hi", 64'(hi_o), 64'(0));
        chk("rst_lo", 64'(lo_o), 64'(0));
        chk("rst_result", 64'(result_o), 64'(0));
        chk("rst_ready", 64'({ready_o, busy_o}), 64'(2'b10));

        // multiply
        run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'h0);
        chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 32'h0);
        chk("multu_hilo", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);

        // divide, including zero divisor and overflow case
        run_op(MD_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'h0);
        chk("div_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(MD_DIVU, 32'd7, 32'd0, 1'b0, 1'b0, 32'h0);
        chk("divu0_hilo", {hi_o, lo_o}, 64'h0000_0007_FFFF_FFFF);
        run_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        chk("div_ovf_hilo", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
        run_op(MD_DIV,  32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0, 32'h0);

        // accumulate
        mt(1'b1, 1'b0, 32'h0);
        mt(1'b0, 1'b1, 32'd10);
        run_op(MD_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
        chk("maddu_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_000B);
        run_op(MD_MSUB, 32'd1, 32'd1, 1'b0, 1'b0, 32'h0);
        chk("msub_lo", 64'(lo_o), 64'h0000_000A);

        // flush a divide mid-flight
        @(negedge clk);
        valid_i = 1'b1; op_i = MD_DIV; a_i = 32'd100; b_i = 32'd7;
        @(posedge clk);
        #1 valid_i = 1'b0;
        watch_no_done("flush_pre_done", 9);
        @(negedge clk);
        flush_i = 1'b1;
        @(posedge clk);
        #1 flush_i = 1'b0;
        @(negedge clk);
        chk("flush_ready", 64'(ready_o), 64'(1));
        chk("flush_hilo", {hi_o, lo_o}, {m_hi, m_lo});
        watch_no_done("flush_no_done", 40);
        run_op(MD_MULT, 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0, 32'h0);

        // flush alongside valid in idle blocks acceptance
        @(negedge clk);
        valid_i = 1'b1; flush_i = 1'b1; op_i = MD_MULT; a_i = 32'd9; b_i = 32'd9;
        @(posedge clk);
        #1 valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("flush_idle_ready", 64'(ready_o), 64'(1));
        watch_no_done("flush_idle_no_done", 8);
        chk("flush_idle_hilo", {hi_o, lo_o}, {m_hi, m_lo});

        // MUL leaves HI/LO; MTLO on MUL commit lands, MTHI on MULT commit loses
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        run_op(MD_MUL, 32'd5, 32'd6, 1'b0, 1'b0, 32'h0);
        chk("mul_result", 64'(result_o), 64'd30);
        chk("mul_hilo", {hi_o, lo_o}, 64'h0000_0011_0000_0022);
        run_op(MD_MUL,  32'd7, 32'd8, 1'b0, 1'b1, 32'h55);
        chk("mul_mtlo", 64'(lo_o), 64'h55);
        run_op(MD_MULT, 32'd2, 32'd3, 1'b1, 1'b0, 32'hAA);
        chk("mult_beats_mthi", 64'(hi_o), 64'h0);

        // random mix
        for (int i = 0; i < 10; i++) begin
            rop = md_op_t'(4'($urandom_range(0, 8)));
            run_op(rop, $urandom, (i == 3) ? 32'h0 : $urandom, 1'b0, 1'b0, 32'h0);
        end

        // reset mid-operation
        @(negedge clk);
        valid_i = 1'b1; op_i = MD_DIVU; a_i = 32'd1000; b_i = 32'd3;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        chk("midrst_hilo", {hi_o, lo_o}, 64'h0);
        chk("midrst_ready", 64'({ready_o, busy_o}), 64'(2'b10));
        chk("midrst_result", 64'(result_o), 64'(0));
        watch_no_done("midrst_no_done", 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
